// File: rtl/mc_ctrl_pkg.sv
// Shared opcode/funct constants, controller state encoding and datapath mux-select codes.
// MC_CTRL_PERF_EN (optional) adds cycle/instruction counters to mc_ctrl; nothing here depends on it.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] FN_JR     = 6'h08;

  localparam logic [1:0] PCS_ALU     = 2'd0;
  localparam logic [1:0] PCS_ALUOUT  = 2'd1;
  localparam logic [1:0] PCS_JUMP    = 2'd2;
  localparam logic [1:0] PCS_RS      = 2'd3;
  localparam logic [1:0] RD_RT       = 2'd0;
  localparam logic [1:0] RD_RD       = 2'd1;
  localparam logic [1:0] RD_RA       = 2'd2;
  localparam logic [1:0] M2R_ALUOUT  = 2'd0;
  localparam logic [1:0] M2R_MEM     = 2'd1;
  localparam logic [1:0] M2R_PC      = 2'd2;
  localparam logic [1:0] ASB_RDATA2  = 2'd0;
  localparam logic [1:0] ASB_FOUR    = 2'd1;
  localparam logic [1:0] ASB_IMM     = 2'd2;
  localparam logic [1:0] ASB_IMM_SH2 = 2'd3;
  localparam logic [1:0] AOP_ADD     = 2'd0;
  localparam logic [1:0] AOP_SUB     = 2'd1;
  localparam logic [1:0] AOP_FUNCT   = 2'd2;
  localparam logic [1:0] AOP_IMM     = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
    S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_BUSERR
  } state_e;

  // S_FETCH doubles as the "undecodable" marker since illegal ops return straight to fetch.
  function automatic state_e dispatch(input logic [5:0] op, input logic [5:0] funct);
    state_e s;
    s = S_FETCH;
    case (op)
      OP_LW, OP_SW:                            s = S_MEMADR;
      OP_R_FORM:                               s = (funct == FN_JR) ? S_JR : S_EXEC;
      OP_BEQ, OP_BNE:                          s = S_BRANCH;
      OP_J:                                    s = S_JUMP;
      OP_JAL:                                  s = S_JAL;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: s = S_IEXEC;
      default:                                 s = S_FETCH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between the instruction register/memory and the multicycle datapath controls.
// MC_CTRL_PERF_EN adds CycleCnt/InstrCnt to the bundle.
interface mc_ctrl_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemAck;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       IRWrite;
  logic       MemReq;
  logic       MemWrite;
  logic       IorD;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemToReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       InstrDone;
  logic       IllegalOp;
  logic       BusErr;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] CycleCnt;
  logic [31:0] InstrCnt;

  modport master (
    input  Op, Funct, Zero, MemAck,
    output PCWrite, PCSrc, IRWrite, MemReq, MemWrite, IorD, RegWrite, RegDst,
           MemToReg, ALUSrcA, ALUSrcB, ALUOp, InstrDone, IllegalOp, BusErr,
           CycleCnt, InstrCnt
  );
  modport slave (
    output Op, Funct, Zero, MemAck,
    input  PCWrite, PCSrc, IRWrite, MemReq, MemWrite, IorD, RegWrite, RegDst,
           MemToReg, ALUSrcA, ALUSrcB, ALUOp, InstrDone, IllegalOp, BusErr,
           CycleCnt, InstrCnt
  );
`else
  modport master (
    input  Op, Funct, Zero, MemAck,
    output PCWrite, PCSrc, IRWrite, MemReq, MemWrite, IorD, RegWrite, RegDst,
           MemToReg, ALUSrcA, ALUSrcB, ALUOp, InstrDone, IllegalOp, BusErr
  );
  modport slave (
    output Op, Funct, Zero, MemAck,
    input  PCWrite, PCSrc, IRWrite, MemReq, MemWrite, IorD, RegWrite, RegDst,
           MemToReg, ALUSrcA, ALUSrcB, ALUOp, InstrDone, IllegalOp, BusErr
  );
`endif
endinterface

// File: rtl/mc_wait_timer.sv
// Counts consecutive unacknowledged memory-request cycles; timeout_o flags the cycle the count hits MAX_WAIT.
// Combinational timeout from the registered count; an ack in that same cycle suppresses it. MAX_WAIT=0 disables.
module mc_wait_timer #(
  parameter int MAX_WAIT = 0,
  parameter int WAIT_W   = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic req_i,
  input  logic ack_i,
  input  logic clr_i,
  output logic timeout_o
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || ack_i || !req_i) cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Fires while the count would step onto MAX_WAIT, so the error state follows MAX_WAIT wait cycles.
  assign timeout_o = (MAX_WAIT != 0) && req_i && !ack_i && (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute of one instruction and drives every datapath control.
// Define MC_CTRL_PERF_EN to add the CycleCnt/InstrCnt performance counters.
module mc_ctrl #(
  parameter int MAX_WAIT = 0,
  parameter int WAIT_W   = 8
) (
  input  logic      CLK,
  input  logic      RST,
  mc_ctrl_if.master bus
);
  import mc_ctrl_pkg::*;

  state_e state_q, state_d, dispatch_st;
  logic   mem_req, timeout, bus_err_q;

  assign dispatch_st = dispatch(bus.Op, bus.Funct);
  assign mem_req     = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  mc_wait_timer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_wait_timer (
    .CLK       (CLK),
    .RST       (RST),
    .req_i     (mem_req),
    .ack_i     (bus.MemAck),
    .clr_i     (state_d != state_q),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.MemAck) state_d = S_DECODE; else if (timeout) state_d = S_BUSERR;
      S_DECODE: state_d = dispatch_st;
      S_MEMADR: state_d = (bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.MemAck) state_d = S_MEMWB; else if (timeout) state_d = S_BUSERR;
      S_MEMWR:  if (bus.MemAck) state_d = S_FETCH; else if (timeout) state_d = S_BUSERR;
      S_EXEC:   state_d = S_ALUWB;
      S_IEXEC:  state_d = S_IWB;
      S_BUSERR: state_d = S_BUSERR;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_FETCH;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_err_q <= (state_d == S_BUSERR);
    end
  end

  always_comb begin
    bus.PCWrite   = 1'b0;
    bus.PCSrc     = PCS_ALU;
    bus.IRWrite   = 1'b0;
    bus.MemReq    = mem_req;
    bus.MemWrite  = 1'b0;
    bus.IorD      = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.RegDst    = RD_RT;
    bus.MemToReg  = M2R_ALUOUT;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = ASB_RDATA2;
    bus.ALUOp     = AOP_ADD;
    bus.InstrDone = 1'b0;
    bus.IllegalOp = 1'b0;
    bus.BusErr    = bus_err_q;
    case (state_q)
      S_FETCH: begin
        bus.ALUSrcB = ASB_FOUR;
        bus.IRWrite = bus.MemAck;
        bus.PCWrite = bus.MemAck;
      end
      S_DECODE: begin
        bus.ALUSrcB   = ASB_IMM_SH2;
        bus.IllegalOp = (dispatch_st == S_FETCH);
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = ASB_IMM;
      end
      S_MEMRD: bus.IorD = 1'b1;
      S_MEMWB: begin
        bus.RegWrite  = 1'b1;
        bus.MemToReg  = M2R_MEM;
        bus.InstrDone = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite  = 1'b1;
        bus.IorD      = 1'b1;
        bus.InstrDone = bus.MemAck;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = AOP_FUNCT;
      end
      S_ALUWB: begin
        bus.RegWrite  = 1'b1;
        bus.RegDst    = RD_RD;
        bus.InstrDone = 1'b1;
      end
      S_IEXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = ASB_IMM;
        bus.ALUOp   = (bus.Op == OP_ADDI) ? AOP_ADD : AOP_IMM;
      end
      S_IWB: begin
        bus.RegWrite  = 1'b1;
        bus.InstrDone = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUOp     = AOP_SUB;
        bus.PCSrc     = PCS_ALUOUT;
        bus.PCWrite   = (bus.Op == OP_BNE) ? !bus.Zero : bus.Zero;
        bus.InstrDone = 1'b1;
      end
      S_JUMP: begin
        bus.PCWrite   = 1'b1;
        bus.PCSrc     = PCS_JUMP;
        bus.InstrDone = 1'b1;
      end
      // PC+4 already sits in the PC, so the link value and the jump land on the same edge.
      S_JAL: begin
        bus.RegWrite  = 1'b1;
        bus.RegDst    = RD_RA;
        bus.MemToReg  = M2R_PC;
        bus.PCWrite   = 1'b1;
        bus.PCSrc     = PCS_JUMP;
        bus.InstrDone = 1'b1;
      end
      S_JR: begin
        bus.PCWrite   = 1'b1;
        bus.PCSrc     = PCS_RS;
        bus.InstrDone = 1'b1;
      end
      default: ;
    endcase
    if (RST) begin
      bus.PCWrite   = 1'b0;
      bus.IRWrite   = 1'b0;
      bus.MemReq    = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.RegWrite  = 1'b0;
      bus.InstrDone = 1'b0;
      bus.IllegalOp = 1'b0;
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (state_q != S_BUSERR) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (bus.InstrDone)       instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign bus.CycleCnt = cycle_cnt_q;
  assign bus.InstrCnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control words queued at stimulus time, compared at negedge.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  typedef enum {T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR, T_EXEC,
                T_ALUWB, T_IEXEC, T_IWB, T_BRANCH, T_JUMP, T_JAL, T_JR, T_BUSERR} tst_e;

  typedef struct packed {
    logic pcw; logic [1:0] pcsrc; logic irw; logic mreq; logic mwr; logic iord;
    logic rw; logic [1:0] rdst; logic [1:0] m2r; logic asa; logic [1:0] asb;
    logic [1:0] aop; logic done; logic ill; logic berr;
  } ctl_t;

  typedef struct { tst_e st; logic ack; logic [5:0] op; logic [5:0] fn; logic z; } stim_t;
  typedef struct { ctl_t e; ctl_t m; } exp_t;

  logic CLK = 1'b0;
  logic RST;
  mc_ctrl_if bus ();

  mc_ctrl #(.MAX_WAIT(4), .WAIT_W(8)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  stim_t      stim_q[$];
  exp_t       exp_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [5:0] cur_op, cur_fn;
  logic       cur_z;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic legal_op(input logic [5:0] op);
    case (op)
      OP_R_FORM, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected controls per state; m marks which fields the behaviour actually defines.
  function automatic void model(input tst_e st, input logic [5:0] op, input logic z,
                                input logic ack, output ctl_t e, output ctl_t m);
    e = '0;
    m = '0;
    {m.pcw, m.irw, m.mreq, m.mwr, m.rw, m.done, m.ill, m.berr} = '1;
    case (st)
      T_RST:    m.berr = 1'b0;
      T_FETCH: begin
        e.mreq = 1'b1; m.iord = 1'b1; e.asb = 2'd1; m.asb = '1; m.asa = 1'b1; m.aop = '1;
        if (ack) begin e.irw = 1'b1; e.pcw = 1'b1; m.pcsrc = '1; end
      end
      T_DECODE: begin
        m.asa = 1'b1; e.asb = 2'd3; m.asb = '1; m.aop = '1; e.ill = !legal_op(op);
      end
      T_MEMADR: begin e.asa = 1'b1; m.asa = 1'b1; e.asb = 2'd2; m.asb = '1; m.aop = '1; end
      T_MEMRD:  begin e.mreq = 1'b1; e.iord = 1'b1; m.iord = 1'b1; end
      T_MEMWB:  begin e.rw = 1'b1; m.rdst = '1; e.m2r = 2'd1; m.m2r = '1; e.done = 1'b1; end
      T_MEMWR:  begin e.mreq = 1'b1; e.mwr = 1'b1; e.iord = 1'b1; m.iord = 1'b1; e.done = ack; end
      T_EXEC:   begin e.asa = 1'b1; m.asa = 1'b1; m.asb = '1; e.aop = 2'd2; m.aop = '1; end
      T_ALUWB:  begin e.rw = 1'b1; e.rdst = 2'd1; m.rdst = '1; m.m2r = '1; e.done = 1'b1; end
      T_IEXEC: begin
        e.asa = 1'b1; m.asa = 1'b1; e.asb = 2'd2; m.asb = '1; m.aop = '1;
        e.aop = (op == OP_ADDI) ? 2'd0 : 2'd3;
      end
      T_IWB:    begin e.rw = 1'b1; m.rdst = '1; m.m2r = '1; e.done = 1'b1; end
      T_BRANCH: begin
        e.asa = 1'b1; m.asa = 1'b1; m.asb = '1; e.aop = 2'd1; m.aop = '1;
        e.pcsrc = 2'd1; m.pcsrc = '1; e.done = 1'b1;
        e.pcw = (op == OP_BNE) ? !z : z;
      end
      T_JUMP:   begin e.pcw = 1'b1; e.pcsrc = 2'd2; m.pcsrc = '1; e.done = 1'b1; end
      T_JAL: begin
        e.rw = 1'b1; e.rdst = 2'd2; m.rdst = '1; e.m2r = 2'd2; m.m2r = '1;
        e.pcw = 1'b1; e.pcsrc = 2'd2; m.pcsrc = '1; e.done = 1'b1;
      end
      T_JR:     begin e.pcw = 1'b1; e.pcsrc = 2'd3; m.pcsrc = '1; e.done = 1'b1; end
      T_BUSERR: e.berr = 1'b1;
      default: ;
    endcase
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.pcw = bus.PCWrite;   c.pcsrc = bus.PCSrc;   c.irw = bus.IRWrite;  c.mreq = bus.MemReq;
    c.mwr = bus.MemWrite;  c.iord = bus.IorD;     c.rw = bus.RegWrite;  c.rdst = bus.RegDst;
    c.m2r = bus.MemToReg;  c.asa = bus.ALUSrcA;   c.asb = bus.ALUSrcB;  c.aop = bus.ALUOp;
    c.done = bus.InstrDone; c.ill = bus.IllegalOp; c.berr = bus.BusErr;
    return c;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic push(input tst_e st, input logic ack);
    stim_t s;
    exp_t  x;
    s.st = st; s.ack = ack; s.op = cur_op; s.fn = cur_fn; s.z = cur_z;
    model(st, cur_op, cur_z, ack, x.e, x.m);
    stim_q.push_back(s);
    exp_q.push_back(x);
  endtask

  task automatic drain();
    stim_t       s;
    exp_t        x;
    logic [19:0] got, want;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      RST = (s.st == T_RST);
      bus.Op = s.op; bus.Funct = s.fn; bus.Zero = s.z; bus.MemAck = s.ack;
      @(negedge CLK);
      x    = exp_q.pop_front();
      got  = sample() & x.m;
      want = x.e & x.m;
      check_eq($sformatf("%s op=%h cyc=%0d", s.st.name(), s.op, cyc), 32'(got), 32'(want));
      cyc++;
      @(posedge CLK);
      #1;
    end
  endtask

  // Builds the full expected state walk for one instruction from its opcode class.
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fetch_wait, input int mem_wait);
    cur_op = op; cur_fn = fn; cur_z = z;
    repeat (fetch_wait) push(T_FETCH, 1'b0);
    push(T_FETCH, 1'b1);
    push(T_DECODE, rnd());
    case (op)
      OP_LW: begin
        push(T_MEMADR, rnd());
        repeat (mem_wait) push(T_MEMRD, 1'b0);
        push(T_MEMRD, 1'b1);
        push(T_MEMWB, rnd());
      end
      OP_SW: begin
        push(T_MEMADR, rnd());
        repeat (mem_wait) push(T_MEMWR, 1'b0);
        push(T_MEMWR, 1'b1);
      end
      OP_R_FORM: begin
        if (fn == FN_JR) push(T_JR, rnd());
        else begin push(T_EXEC, rnd()); push(T_ALUWB, rnd()); end
      end
      OP_BEQ, OP_BNE: push(T_BRANCH, rnd());
      OP_J:           push(T_JUMP, rnd());
      OP_JAL:         push(T_JAL, rnd());
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: begin
        push(T_IEXEC, rnd());
        push(T_IWB, rnd());
      end
      default: ;
    endcase
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    bus.Op = OP_LW; bus.Funct = '0; bus.Zero = 1'b0; bus.MemAck = 1'b1;
    cur_op = OP_LW; cur_fn = '0; cur_z = 1'b0;
    @(posedge CLK);
    #1;
    push(T_RST, 1'b1);
    push(T_RST, 1'b1);
    drain();

    instr(OP_LW,     6'h00, 1'b0, 0, 0);
    instr(OP_R_FORM, 6'h20, 1'b0, 3, 0);
    instr(OP_BEQ,    6'h00, 1'b1, 0, 0);
    instr(OP_BEQ,    6'h00, 1'b0, 0, 0);
    instr(OP_BNE,    6'h00, 1'b1, 0, 0);
    instr(OP_BNE,    6'h00, 1'b0, 0, 0);
    instr(OP_JAL,    6'h00, 1'b0, 0, 0);
    instr(OP_J,      6'h00, 1'b0, 1, 0);
    instr(OP_R_FORM, FN_JR, 1'b0, 0, 0);
    instr(6'h3F,     6'h00, 1'b0, 0, 0);
    instr(OP_SW,     6'h00, 1'b0, 1, 2);
    instr(OP_LW,     6'h00, 1'b0, 2, 3);
    instr(OP_ADDI,   6'h00, 1'b0, 0, 0);
    instr(OP_ORI,    6'h00, 1'b0, 0, 0);
    instr(OP_SLTI,   6'h00, 1'b0, 0, 0);

    // Fetch never acknowledged: four wait cycles, then the sticky error state.
    cur_op = OP_R_FORM; cur_fn = 6'h20; cur_z = 1'b0;
    repeat (4) push(T_FETCH, 1'b0);
    repeat (3) push(T_BUSERR, rnd());
    push(T_RST, 1'b0);
    drain();
    instr(OP_R_FORM, 6'h20, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM that sequences the shared datapath (PC, instruction register, register file/decode stage, ALU, unified memory) one instruction at a time.
- Decodes opcode/funct and issues per-cycle enables and mux selects.
- Handshakes with a variable-latency memory and detects bus timeouts.
- Sits between the instruction register output and every datapath control input.

Parameters:
- MAX_WAIT, 0, cycles MemReq may stay unacknowledged before bus error; 0 = timeout disabled.
- WAIT_W, 8, width of the wait counter; MAX_WAIT < 2^WAIT_W.

Ports:
- CLK  in  1  clock, all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- Op  in  6  Ins[31:26] from instruction register.
- Funct  in  6  Ins[5:0].
- Zero  in  1  ALU zero flag, valid in BRANCH.
- MemAck  in  1  memory completes current request this cycle.
- PCWrite  out  1  load PC (already qualified by Zero for BEQ/BNE).
- PCSrc  out  2  0 ALU result, 1 ALUOut reg (branch target), 2 jump target, 3 Rdata1 (JR).
- IRWrite  out  1  load instruction register.
- MemReq  out  1  memory request.
- MemWrite  out  1  request is a write.
- IorD  out  1  0 address=PC, 1 address=ALUOut.
- RegWrite  out  1  register-file write enable.
- RegDst  out  2  0 rt, 1 rd, 2 $31.
- MemToReg  out  2  0 ALUOut, 1 memory data, 2 PC.
- ALUSrcA  out  1  0 PC, 1 Rdata1.
- ALUSrcB  out  2  0 Rdata2, 1 const 4, 2 Ed32, 3 Ed32<<2.
- ALUOp  out  2  0 add, 1 sub, 2 use Funct, 3 use Op (immediate logic).
- InstrDone  out  1  one-cycle pulse in an instruction's final state.
- IllegalOp  out  1  one-cycle pulse on undecodable opcode/funct.
- BusErr  out  1  sticky timeout flag.

Behaviour:
- Outputs are Moore, decoded from state only, except PCWrite in BRANCH and handshake-gated signals.
- Reset (RST high at posedge): state=FETCH, wait counter=0, BusErr=0. All enables are 0 during reset, so no PC/IR/RegWrite side effects in the reset cycle.
- Reset mid-operation aborts the instruction. Memory must tolerate MemReq dropping.
- FETCH: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0.
  - On MemAck: IRWrite=1, PCWrite=1, PCSrc=0, next DECODE.
  - Otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (precompute branch target into ALUOut). Dispatch on Op:
  - LW/SW -> MEMADR.
  - R_FORM, Funct=JR -> JR.
  - Other R_FORM -> EXEC.
  - BEQ/BNE -> BRANCH.
  - J -> JUMP.
  - JAL -> JAL.
  - ADDI/ANDI/ORI/XORI/SLTI -> IEXEC.
  - Else IllegalOp=1 -> FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Next MEMRD if LW, MEMWR if SW.
- MEMRD: MemReq=1, IorD=1. On MemAck -> MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemToReg=1, InstrDone=1 -> FETCH.
- MEMWR: MemReq=1, MemWrite=1, IorD=1. On MemAck: InstrDone=1 -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2 -> ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemToReg=0, InstrDone=1 -> FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=2, ALUOp=3 (ADDI uses 0) -> IWB.
- IWB: RegWrite=1, RegDst=0, MemToReg=0, InstrDone=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSrc=1.
  - PCWrite = Zero for BEQ, ~Zero for BNE.
  - InstrDone=1 -> FETCH.
- JUMP: PCWrite=1, PCSrc=2, InstrDone=1 -> FETCH.
- JAL: RegWrite=1, RegDst=2, MemToReg=2, PCWrite=1, PCSrc=2, InstrDone=1 -> FETCH. Register write and PC update occur on the same edge; the written value is the already-incremented PC.
- JR: PCWrite=1, PCSrc=3, InstrDone=1 -> FETCH.
- Latency with zero-wait memory (ack in the request cycle):
  - LW 5 cycles.
  - R-type, SW, I-ALU 4 cycles.
  - BEQ/BNE, J, JAL, JR 3 cycles.
  - Each memory wait cycle adds 1.
- MemAck is ignored when MemReq=0.
- Wait counter:
  - Increments each cycle MemReq=1 and MemAck=0; clears on ack or state change.
  - If MAX_WAIT != 0 and the counter reaches MAX_WAIT: next state BUSERR.
- BUSERR: all enables 0, BusErr=1. Exit only via RST.
- An ack arriving on the same cycle the counter reaches MAX_WAIT wins: no error.

Optional Feature:
- MC_CTRL_PERF_EN defined: adds outputs CycleCnt[31:0] and InstrCnt[31:0].
  - CycleCnt increments every non-reset cycle except in BUSERR.
  - InstrCnt increments on InstrDone.
  - Both wrap at 2^32 and clear on RST.
- Undefined: ports absent; no counters.

Decomposition:
- Opcode/funct constants (R_FORM, LW, SW, BEQ, BNE, J, JAL, JR, ADDI, ANDI, ORI, XORI, SLTI) and state encodings belong in common_param.vh.
- Mux-select encodings (PCSrc, RegDst, MemToReg, ALUSrcB, ALUOp) also go there, shared with the datapath.
- One sub-module: mc_wait_timer, holding the wait counter and timeout compare, parameterised by MAX_WAIT and WAIT_W.

Test Plan:
- RST high 2 cycles, then LW with MemAck tied 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegWrite=1, MemToReg=1 in cycle 5; InstrDone pulses once.
- R-type ADD fetch with MemAck delayed 3 cycles -> MemReq held 4 cycles; IRWrite only on the ack cycle; ALUWB in cycle 7.
- BEQ with Zero=1, then Zero=0 -> PCWrite=1 with PCSrc=1 vs PCWrite=0; both 3 cycles.
- JAL -> third cycle: RegWrite=1, RegDst=2, MemToReg=2, PCWrite=1, PCSrc=2.
- Opcode 6'h3F -> IllegalOp pulses in DECODE; next cycle FETCH; no RegWrite.
- MAX_WAIT=4, MemAck held 0 -> BUSERR after 4 wait cycles, BusErr=1 sticky. RST clears it and restarts at FETCH.
